toplama_seri: RTL and testbench

Parametrised multi-cycle adder/subtractor for the calculator datapath. It accepts two GENISLIK-bit operands and an operation code on a start handshake. It processes ADIM bits per clock through a registered carry chain and returns an exact, extended result on the shared 2·GENISLIK-bit result bus, along with an overflow flag and a one-cycle valid pulse. It sits beside the other arithmetic units behind the top-level operation selector.

---
 rtl/toplama_pkg.sv | 20 ++
 rtl/toplama_dilim.sv | 22 ++
 rtl/toplama_seri.sv | 151 +++++++++++++++
 tb/tb_toplama_seri.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/toplama_pkg.sv
// Shared definitions for the serial adder/subtractor: tur field layout,
// FSM state encoding and the operand/slice width sanity check.
package toplama_pkg;

    localparam int   TUR_CIKAR    = 0;    // tur bit: 1 = subtract
    localparam int   TUR_ISARETLI = 1;    // tur bit: 1 = signed operands
    localparam int   TUR_AYRILMIS = 2;    // tur bit: reserved, 1 = illegal
    localparam logic TUR_TOPLA    = 1'b0; // value of tur[TUR_CIKAR] selecting add

    typedef enum logic [1:0] {
        BOS   = 2'd0,
        HESAP = 2'd1,
        BITTI = 2'd2
    } durum_t;

    function automatic bit genislik_uygun(input int genislik, input int adim);
        return (adim > 0) && (genislik >= adim) && ((genislik % adim) == 0);
    endfunction

endpackage

// File: rtl/toplama_dilim.sv
// Combinational ADIM-bit adder slice; also reports the carry into its msb
// so the top can derive signed overflow on the final slice.
module toplama_dilim #(
    parameter int ADIM = 8
) (
    input  logic [ADIM-1:0] a,
    input  logic [ADIM-1:0] b,
    input  logic            cin,
    output logic [ADIM-1:0] s,
    output logic            cout,
    output logic            c_msb
);

    logic [ADIM:0] toplam;

    assign toplam = {1'b0, a} + {1'b0, b} + {{ADIM{1'b0}}, cin};
    assign s      = toplam[ADIM-1:0];
    assign cout   = toplam[ADIM];
    // sum bit = a ^ b ^ carry-in, so the carry into the msb falls out directly
    assign c_msb  = toplam[ADIM-1] ^ a[ADIM-1] ^ b[ADIM-1];

endmodule

// File: rtl/toplama_seri.sv
// Multi-cycle adder/subtractor processing ADIM bits per clock.
// Optional macro TOPLAMA_ERKEN_BITIS_EN: early finish for unsigned add.
module toplama_seri
    import toplama_pkg::*;
#(
    parameter int GENISLIK = 32,
    parameter int ADIM     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  basla,
    input  logic [GENISLIK-1:0]   sayi1,
    input  logic [GENISLIK-1:0]   sayi2,
    input  logic [2:0]            tur,
    output logic [2*GENISLIK-1:0] sonuc,
    output logic                  tasma,
    output logic                  hata,
    output logic                  hazir,
    output logic                  gecerli
);

    localparam int N  = GENISLIK / ADIM;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] SON_IDX = IW'(N - 1);

    generate
        if (!genislik_uygun(GENISLIK, ADIM)) begin : g_genislik_hatasi
            $error("toplama_seri: GENISLIK must be a positive multiple of ADIM");
        end
    endgenerate

    durum_t                durum_reg, durum_next;
    logic [GENISLIK-1:0]   a_reg, b_reg, toplam_reg, toplam_next;
    logic [2:0]            tur_reg;
    logic                  carry_reg;
    logic [IW-1:0]         idx_reg;
    logic [2*GENISLIK-1:0] sonuc_reg, sonuc_next;
    logic                  tasma_reg, tasma_next, hata_reg, gecerli_reg;
    logic [ADIM-1:0]       dilim_s;
    logic                  dilim_cout, dilim_cmsb;
    logic                  ekstra, erken, bitis;

    // Operands shift right each chunk, so the slice always sees the low chunk
    toplama_dilim #(.ADIM(ADIM)) u_dilim (
        .a     (a_reg[ADIM-1:0]),
        .b     (b_reg[ADIM-1:0]),
        .cin   (carry_reg),
        .s     (dilim_s),
        .cout  (dilim_cout),
        .c_msb (dilim_cmsb)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_toplam
            assign toplam_next[gi*ADIM +: ADIM] =
                (idx_reg == IW'(gi)) ? dilim_s : toplam_reg[gi*ADIM +: ADIM];
        end
    endgenerate

`ifdef TOPLAMA_ERKEN_BITIS_EN
    assign erken = (tur_reg == 3'b000) && ((a_reg >> ADIM) == '0) &&
                   ((b_reg >> ADIM) == '0) && !dilim_cout;
`else
    assign erken = 1'b0;
`endif
    assign bitis = (idx_reg == SON_IDX) || erken;

    always_comb begin
        ekstra     = dilim_cout;
        tasma_next = dilim_cout;
        if (tur_reg[TUR_ISARETLI]) begin
            ekstra     = a_reg[ADIM-1] ^ b_reg[ADIM-1] ^ dilim_cout;
            tasma_next = dilim_cmsb ^ dilim_cout;
        end else if (tur_reg[TUR_CIKAR] != TUR_TOPLA) begin
            ekstra     = ~dilim_cout;
            tasma_next = ~dilim_cout;
        end
        if (!tur_reg[TUR_ISARETLI] && (tur_reg[TUR_CIKAR] == TUR_TOPLA))
            sonuc_next = {{(GENISLIK-1){1'b0}}, ekstra, toplam_next};
        else
            sonuc_next = {{GENISLIK{ekstra}}, toplam_next};
        if (tur_reg[TUR_AYRILMIS]) begin
            sonuc_next = '0;
            tasma_next = 1'b0;
        end
    end

    always_comb begin
        durum_next = durum_reg;
        case (durum_reg)
            BOS:     if (basla) durum_next = HESAP;
            HESAP:   if (bitis) durum_next = BITTI;
            BITTI:   durum_next = BOS;
            default: durum_next = BOS;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) durum_reg <= BOS;
        else        durum_reg <= durum_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg       <= '0;
            b_reg       <= '0;
            toplam_reg  <= '0;
            tur_reg     <= '0;
            carry_reg   <= 1'b0;
            idx_reg     <= '0;
            sonuc_reg   <= '0;
            tasma_reg   <= 1'b0;
            hata_reg    <= 1'b0;
            gecerli_reg <= 1'b0;
        end else begin
            gecerli_reg <= 1'b0;
            case (durum_reg)
                BOS: if (basla) begin
                    a_reg      <= sayi1;
                    b_reg      <= tur[TUR_CIKAR] ? ~sayi2 : sayi2;
                    carry_reg  <= tur[TUR_CIKAR];
                    tur_reg    <= tur;
                    idx_reg    <= '0;
                    toplam_reg <= '0;
                end
                HESAP: begin
                    a_reg      <= a_reg >> ADIM;
                    b_reg      <= b_reg >> ADIM;
                    carry_reg  <= dilim_cout;
                    toplam_reg <= toplam_next;
                    idx_reg    <= idx_reg + 1'b1;
                    if (bitis) begin
                        sonuc_reg   <= sonuc_next;
                        tasma_reg   <= tasma_next;
                        hata_reg    <= tur_reg[TUR_AYRILMIS];
                        gecerli_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sonuc   = sonuc_reg;
    assign tasma   = tasma_reg;
    assign hata    = hata_reg;
    assign gecerli = gecerli_reg;
    assign hazir   = (durum_reg == BOS);

endmodule

// File: tb/tb_toplama_seri.sv
// Self-checking bench for toplama_seri: directed and random operations
// against an arithmetic reference model, plus busy-ignore and reset abort.
module tb_toplama_seri;

    localparam int N = 4;
    localparam longint U32MAX = 64'h0000_0000_FFFF_FFFF;
    localparam longint S32MAX = 64'h0000_0000_7FFF_FFFF;
    localparam longint S32MIN = -64'sh0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst_n, basla;
    logic [31:0] sayi1, sayi2;
    logic [2:0]  tur;
    logic [63:0] sonuc;
    logic        tasma, hata, hazir, gecerli;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    toplama_seri #(.GENISLIK(32), .ADIM(8)) dut (
        .clk(clk), .rst_n(rst_n), .basla(basla), .sayi1(sayi1), .sayi2(sayi2),
        .tur(tur), .sonuc(sonuc), .tasma(tasma), .hata(hata), .hazir(hazir),
        .gecerli(gecerli)
    );

    // Exact arithmetic in 64-bit integers, then range tests for overflow
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [2:0] t, output logic [63:0] s,
                                  output logic ov, output logic h);
        longint sa, sb, r;
        sa = t[1] ? longint'($signed(a)) : longint'({32'b0, a});
        sb = t[1] ? longint'($signed(b)) : longint'({32'b0, b});
        r  = t[0] ? (sa - sb) : (sa + sb);
        s  = r;
        if (t[1])      ov = (r > S32MAX) || (r < S32MIN);
        else if (t[0]) ov = (r < 0);
        else           ov = (r > U32MAX);
        h = 1'b0;
        if (t[2]) begin
            s  = '0;
            ov = 1'b0;
            h  = 1'b1;
        end
    endfunction

    // Edges from accept to the gecerli cycle
    function automatic int model_gecikme(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] t);
        int k;
        k = N;
`ifdef TOPLAMA_ERKEN_BITIS_EN
        if (t == 3'b000) begin
            for (int j = N; j >= 1; j--) begin
                longint unsigned m, ua, ub;
                m  = 64'd1 << (8 * j);
                ua = {32'b0, a};
                ub = {32'b0, b};
                if ((ua / m == 0) && (ub / m == 0) && ((ua % m) + (ub % m) < m))
                    k = j;
            end
        end
`else
        if (t[2] && a == b) k = N;
`endif
        return k;
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] t, input bit disturb, input string ad);
        logic [63:0] es, got_s;
        logic        eo, eh, got_o, got_h;
        int          elat, seen;
        model(a, b, t, es, eo, eh);
        elat  = model_gecikme(a, b, t);
        got_s = '0; got_o = 1'b0; got_h = 1'b0;
        @(negedge clk);
        checks++;
        if (hazir !== 1'b1) begin
            errors++;
            $display("FAIL %s hazir_before got=%b want=1", ad, hazir);
        end
        sayi1 = a; sayi2 = b; tur = t; basla = 1'b1;
        @(posedge clk);
        #1;
        sayi1 = $urandom; sayi2 = $urandom; tur = 3'($urandom_range(0, 7));
        basla = disturb;
        seen = 0;
        for (int k = 1; k <= 20 && seen == 0; k++) begin
            @(posedge clk);
            #1;
            if (gecerli === 1'b1) begin
                seen  = k;
                got_s = sonuc; got_o = tasma; got_h = hata;
                basla = 1'b0;
            end
        end
        basla = 1'b0;
        checks++;
        if (seen != elat) begin
            errors++;
            $display("FAIL %s latency got=%0d want=%0d", ad, seen, elat);
        end
        if (seen != 0) begin
            checks++;
            if (got_s !== es) begin
                errors++;
                $display("FAIL %s sonuc got=%h want=%h", ad, got_s, es);
            end
            checks++;
            if (got_o !== eo) begin
                errors++;
                $display("FAIL %s tasma got=%b want=%b", ad, got_o, eo);
            end
            checks++;
            if (got_h !== eh) begin
                errors++;
                $display("FAIL %s hata got=%b want=%b", ad, got_h, eh);
            end
            @(posedge clk);
            #1;
            checks++;
            if (hazir !== 1'b1 || gecerli !== 1'b0 || sonuc !== es) begin
                errors++;
                $display("FAIL %s after_done hazir=%b gecerli=%b sonuc=%h want hazir=1 gecerli=0 sonuc=%h",
                         ad, hazir, gecerli, sonuc, es);
            end
        end
        $display("%s: a=%h b=%h tur=%b -> sonuc=%h tasma=%b hata=%b lat=%0d",
                 ad, a, b, t, got_s, got_o, got_h, seen);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; basla = 1'b0; sayi1 = '0; sayi2 = '0; tur = '0;
        #2;
        checks++;
        if (sonuc !== 64'd0 || tasma !== 1'b0 || hata !== 1'b0 ||
            gecerli !== 1'b0 || hazir !== 1'b1) begin
            errors++;
            $display("FAIL reset got sonuc=%h tasma=%b hata=%b gecerli=%b hazir=%b want 0/0/0/0/1",
                     sonuc, tasma, hata, gecerli, hazir);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset: sonuc=%h hazir=%b", sonuc, hazir);
    endtask

    task automatic test_directed();
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 3'b000, 1'b0, "uadd_wrap");
        run_op(32'd5, 32'd7, 3'b001, 1'b0, "usub_borrow");
        run_op(32'd7, 32'd5, 3'b001, 1'b0, "usub_pos");
        run_op(32'h7FFF_FFFF, 32'd1, 3'b010, 1'b0, "sadd_ovf");
        run_op(32'h8000_0000, 32'd1, 3'b011, 1'b0, "ssub_ovf");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b011, 1'b0, "ssub_zero");
    endtask

    task automatic test_busy_ignore();
        run_op(32'h1234_5678, 32'h0FED_CBA9, 3'b000, 1'b1, "busy_uadd");
        run_op(32'h8000_0001, 32'h7FFF_FFFF, 3'b011, 1'b1, "busy_ssub");
    endtask

    task automatic test_hata();
        run_op(32'hDEAD_BEEF, 32'h0000_0042, 3'b100, 1'b0, "hata_100");
        run_op(32'h0000_0003, 32'h0000_0004, 3'b111, 1'b0, "hata_111");
    endtask

    task automatic test_latency();
        run_op(32'd3, 32'd4, 3'b000, 1'b0, "lat_small");
        run_op(32'h0000_00FF, 32'h0000_0001, 3'b000, 1'b0, "lat_carry");
        run_op(32'd3, 32'd4, 3'b010, 1'b0, "lat_signed");
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            logic [31:0] a, b;
            logic [2:0]  t;
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                a = a >> (8 * $urandom_range(1, 3));
                b = b >> (8 * $urandom_range(1, 3));
            end
            t = 3'($urandom_range(0, 3));
            run_op(a, b, t, 1'($urandom_range(0, 1)), "rand");
        end
    endtask

    task automatic test_mid_reset();
        run_op(32'd1, 32'd2, 3'b000, 1'b0, "pre_reset");
        @(negedge clk);
        sayi1 = 32'h1234_5678; sayi2 = 32'h1111_1111; tur = 3'b000; basla = 1'b1;
        @(posedge clk);
        #1;
        basla = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (hazir !== 1'b1 || sonuc !== 64'd0 || tasma !== 1'b0 ||
            hata !== 1'b0 || gecerli !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got hazir=%b sonuc=%h tasma=%b hata=%b gecerli=%b want 1/0/0/0/0",
                     hazir, sonuc, tasma, hata, gecerli);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (gecerli !== 1'b0 || hazir !== 1'b1) begin
                errors++;
                $display("FAIL mid_reset_idle cycle=%0d gecerli=%b hazir=%b want 0/1",
                         k, gecerli, hazir);
            end
        end
        $display("mid_reset: aborted, hazir=%b sonuc=%h", hazir, sonuc);
        run_op(32'd3, 32'd4, 3'b000, 1'b0, "post_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_ignore();
        test_hata();
        test_latency();
        test_random();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
